// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus splice helpers for the trap sequencer.
// No logic of its own; pure definitions.
// Imported by the interface consumer and the sequencer top.
package trap_ctrl_pkg;

  // CSR addresses on the interrupt read/write port
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MIE     = 32'h0000_0304;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_W_MRET    = 3'd4,
    ST_ASSERT    = 3'd5
  } state_e;

  // Trap entry: stash MIE into MPIE, then disable interrupts
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE_BIT] = m[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, MPIE set to 1
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE_BIT]  = m[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Dedicated interrupt read/write port between the trap sequencer and the CSR file.
// Combinational bundle, no latency of its own.
// No backpressure here; EX write priority is signalled separately to the sequencer.
interface trap_ctrl_if;
  logic [31:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_waddr;
  logic [31:0] csr_wdata;

  // Sequencer side
  modport master (
    output csr_raddr,
    input  csr_rdata,
    output csr_we,
    output csr_waddr,
    output csr_wdata
  );

  // CSR file side
  modport slave (
    input  csr_raddr,
    output csr_rdata,
    input  csr_we,
    input  csr_waddr,
    input  csr_wdata
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/mstatus (or restores mstatus) then redirects fetch.
// Trap: writes N+1..N+3, redirect N+4; mret: write N+1, redirect N+2.
// An EX CSR write stalls the current write state one cycle per colliding cycle.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MCAUSE_ECALL  = CAUSE_ECALL,
  parameter logic [31:0] MCAUSE_EBREAK = CAUSE_EBREAK,
  parameter logic [31:0] MCAUSE_TIMER  = CAUSE_TIMER,
  parameter logic [31:0] MCAUSE_EXT    = CAUSE_EXT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic        ex_csr_we_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  trap_ctrl_if.master csr_if,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;
  logic        mret_q,  mret_d;

  logic ext_en, tmr_en, int_pc_sel;
  logic unused_bits;

  assign ext_en = irq_ext_i   & global_int_en_i & csr_if.csr_rdata[MIE_MEIE_BIT];
  assign tmr_en = irq_timer_i & global_int_en_i & csr_if.csr_rdata[MIE_MTIE_BIT];
  // Interrupts resume at the branch target if EX is redirecting this cycle
  assign int_pc_sel = jump_flag_i;

  assign unused_bits = ^{csr_if.csr_rdata[31:12], csr_if.csr_rdata[10:8],
                         csr_if.csr_rdata[6:0], csr_mtvec_i[1:0]};

  // State and latched trap context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mret_q  <= mret_d;
    end
  end

  // Acceptance priority, CSR write sequencing and fetch redirect
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    mret_d           = mret_q;
    hold_o           = 1'b0;
    int_assert_o     = 1'b0;
    int_addr_o       = '0;
    csr_if.csr_raddr = '0;
    csr_if.csr_we    = 1'b0;
    csr_if.csr_waddr = '0;
    csr_if.csr_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        csr_if.csr_raddr = CSR_MIE;
        // Gated by reset so the combinational stall also drops while reset is held
        if (rst) begin
          if (ecall_i) begin
            hold_o = 1'b1; cause_d = MCAUSE_ECALL; epc_d = inst_addr_i;
            mret_d = 1'b0; state_d = ST_W_MEPC;
          end else if (ebreak_i) begin
            hold_o = 1'b1; cause_d = MCAUSE_EBREAK; epc_d = inst_addr_i;
            mret_d = 1'b0; state_d = ST_W_MEPC;
          end else if (mret_i) begin
            hold_o = 1'b1; mret_d = 1'b1; state_d = ST_W_MRET;
          end else if (ext_en) begin
            hold_o = 1'b1; cause_d = MCAUSE_EXT;
            epc_d  = int_pc_sel ? jump_addr_i : inst_addr_i;
            mret_d = 1'b0; state_d = ST_W_MEPC;
          end else if (tmr_en) begin
            hold_o = 1'b1; cause_d = MCAUSE_TIMER;
            epc_d  = int_pc_sel ? jump_addr_i : inst_addr_i;
            mret_d = 1'b0; state_d = ST_W_MEPC;
          end
        end
      end
      ST_W_MEPC: begin
        hold_o = 1'b1;
        csr_if.csr_waddr = CSR_MEPC;
        csr_if.csr_wdata = epc_q;
        if (!ex_csr_we_i) begin
          csr_if.csr_we = 1'b1;
          state_d = ST_W_MCAUSE;
        end
      end
      ST_W_MCAUSE: begin
        hold_o = 1'b1;
        csr_if.csr_waddr = CSR_MCAUSE;
        csr_if.csr_wdata = cause_q;
        if (!ex_csr_we_i) begin
          csr_if.csr_we = 1'b1;
          state_d = ST_W_MSTATUS;
        end
      end
      ST_W_MSTATUS: begin
        hold_o = 1'b1;
        csr_if.csr_waddr = CSR_MSTATUS;
        csr_if.csr_wdata = mstatus_on_trap(csr_mstatus_i);
        if (!ex_csr_we_i) begin
          csr_if.csr_we = 1'b1;
          state_d = ST_ASSERT;
        end
      end
      ST_W_MRET: begin
        hold_o = 1'b1;
        csr_if.csr_waddr = CSR_MSTATUS;
        csr_if.csr_wdata = mstatus_on_mret(csr_mstatus_i);
        if (!ex_csr_we_i) begin
          csr_if.csr_we = 1'b1;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        hold_o       = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized and directed stimulus for trap_ctrl against a queue-based expectation model.
// Each accepted event expands into an ordered list of expected CSR writes and one redirect.
// Colliding EX writes leave the head of that list pending for the cycle.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk, rst;
  logic [31:0] inst_addr, jump_addr, mtvec, mepc, mstatus, mie;
  logic        ecall, ebreak, mret, jump_flag, irq_t, irq_e, ex_we, gie;
  logic        hold, int_assert;
  logic [31:0] int_addr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        redir;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  trap_ctrl_if csr_if ();
  assign csr_if.csr_rdata = mie;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr), .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .irq_timer_i(irq_t), .irq_ext_i(irq_e), .ex_csr_we_i(ex_we),
    .global_int_en_i(gie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(mstatus), .csr_if(csr_if),
    .hold_o(hold), .int_assert_o(int_assert), .int_addr_o(int_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Spec-level mstatus updates expressed as masks
  function automatic logic [31:0] ms_trap(input logic [31:0] m);
    return (m & ~32'h88) | ((m & 32'h8) << 4);
  endfunction
  function automatic logic [31:0] ms_mret(input logic [31:0] m);
    return (m & ~32'h88) | ((m & 32'h80) >> 4) | 32'h80;
  endfunction

  // Compare one cycle of DUT outputs against the model, then advance the model
  task automatic model_step();
    logic        acc, is_trap, e_en, t_en;
    logic [31:0] cause, pc;
    ev_t         ev;
    if (exp_q.size() == 0) begin
      e_en = irq_e & gie & mie[11];
      t_en = irq_t & gie & mie[7];
      acc  = ecall | ebreak | mret | e_en | t_en;
      check_val("hold_idle", hold, acc);
      check_val("we_idle", csr_if.csr_we, 0);
      check_val("assert_idle", int_assert, 0);
      check_val("raddr_idle", csr_if.csr_raddr, 32'h304);
      if (acc) begin
        is_trap = 1'b1; cause = 0; pc = inst_addr;
        if (ecall)       cause = 32'd11;
        else if (ebreak) cause = 32'd3;
        else if (mret)   is_trap = 1'b0;
        else begin
          cause = e_en ? 32'h8000_000B : 32'h8000_0007;
          pc    = jump_flag ? jump_addr : inst_addr;
        end
        if (is_trap) begin
          exp_q.push_back('{1'b0, 32'h341, pc});
          exp_q.push_back('{1'b0, 32'h342, cause});
          exp_q.push_back('{1'b0, 32'h300, ms_trap(mstatus)});
          exp_q.push_back('{1'b1, 32'h0, mtvec & ~32'h3});
        end else begin
          exp_q.push_back('{1'b0, 32'h300, ms_mret(mstatus)});
          exp_q.push_back('{1'b1, 32'h0, mepc});
        end
      end
    end else begin
      ev = exp_q[0];
      check_val("hold_busy", hold, 1);
      if (ev.redir) begin
        check_val("assert", int_assert, 1);
        check_val("int_addr", int_addr, ev.data);
        check_val("we_in_assert", csr_if.csr_we, 0);
        void'(exp_q.pop_front());
      end else begin
        check_val("assert_in_write", int_assert, 0);
        if (ex_we) begin
          check_val("we_collide", csr_if.csr_we, 0);
        end else begin
          check_val("we", csr_if.csr_we, 1);
          check_val("waddr", csr_if.csr_waddr, ev.addr);
          check_val("wdata", csr_if.csr_wdata, ev.data);
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ecall = 0; ebreak = 0; mret = 0; jump_flag = 0; irq_t = 0; irq_e = 0; ex_we = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_hold"}, hold, 0);
    check_val({tag, "_we"}, csr_if.csr_we, 0);
    check_val({tag, "_waddr"}, csr_if.csr_waddr, 0);
    check_val({tag, "_wdata"}, csr_if.csr_wdata, 0);
    check_val({tag, "_assert"}, int_assert, 0);
    check_val({tag, "_int_addr"}, int_addr, 0);
  endtask

  initial begin
    rst = 0; clear_inputs();
    inst_addr = 0; jump_addr = 0; mtvec = 0; mepc = 0; mstatus = 0; mie = 0; gie = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1;
    cycle();

    // Ecall at 0x100, mtvec 0x200, mstatus 0x8
    mtvec = 32'h200; mstatus = 32'h8; inst_addr = 32'h100; ecall = 1;
    cycle(); ecall = 0;
    repeat (5) cycle();

    // mret with mstatus 0x80, mepc 0x104
    mstatus = 32'h80; mepc = 32'h104; mret = 1;
    cycle(); mret = 0;
    repeat (3) cycle();

    // External irq with concurrent jump to 0x300
    mie = 32'h800; gie = 1; mstatus = 32'h8; irq_e = 1; jump_flag = 1;
    jump_addr = 32'h300; inst_addr = 32'h180;
    cycle(); irq_e = 0; jump_flag = 0;
    repeat (5) cycle();

    // Timer and external together: external wins
    mie = 32'h880; irq_t = 1; irq_e = 1;
    cycle(); irq_t = 0; irq_e = 0;
    repeat (5) cycle();

    // Masked interrupts must not start a sequence
    gie = 0; irq_t = 1; irq_e = 1; repeat (3) cycle();
    gie = 1; mie = 0; repeat (3) cycle();
    clear_inputs(); mie = 32'h880;

    // EX writes collide for two cycles during mcause
    inst_addr = 32'h140; ecall = 1;
    cycle(); ecall = 0;
    cycle();
    ex_we = 1; repeat (2) cycle();
    ex_we = 0; repeat (5) cycle();

    // Reset mid-sequence, then a clean ecall
    inst_addr = 32'h1c0; ecall = 1;
    cycle(); ecall = 0;
    cycle();
    rst = 0; #1;
    check_zero_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1;
    inst_addr = 32'h220; ecall = 1;
    cycle(); ecall = 0;
    repeat (5) cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        mtvec   = $urandom;
        mepc    = $urandom;
        mstatus = $urandom;
        mie     = ($urandom & ~32'h880) | ($urandom_range(0, 1) ? 32'h800 : 32'h0)
                | ($urandom_range(0, 1) ? 32'h80 : 32'h0);
        gie     = $urandom_range(0, 3) != 0;
      end
      ecall     = $urandom_range(0, 19) == 0;
      ebreak    = $urandom_range(0, 19) == 0;
      mret      = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 15) == 0) irq_t = ~irq_t;
      if ($urandom_range(0, 15) == 0) irq_e = ~irq_e;
      jump_flag = $urandom_range(0, 1);
      jump_addr = $urandom & ~32'h1;
      inst_addr = $urandom & ~32'h3;
      ex_we     = $urandom_range(0, 3) == 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
